// File: rtl/clkgen_cfg_loader.sv
// clkgen_cfg_loader: serialises {duty, phase} requests into the clock
// generator go/datain load protocol. Optional feature: CLKGEN_LDR_PEND_EN.
module clkgen_cfg_loader #(
  parameter int DW      = 3,
  parameter int MIN_RUN = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [DW-1:0] req_duty,
  input  logic [DW-1:0] req_phase,
  output logic          req_ready,
  input  logic          stop,
  output logic          go,
  output logic [DW-1:0] datain,
  output logic          busy,
  output logic          loaded,
  output logic          err
);

  localparam int CW = $clog2(MIN_RUN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_DUTY,
    S_PHASE,
    S_HOLD,
    S_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          go_q, go_d;
  logic [DW-1:0] din_q, din_d;
  logic          busy_q, busy_d;
  logic          ld_q, ld_d;
  logic          err_q, err_d;
  logic          acc;
  logic          legal;
  logic          hold_last;

`ifdef CLKGEN_LDR_PEND_EN
  logic          pend_q, pend_d;
  logic [DW-1:0] pduty_q, pduty_d;
  logic [DW-1:0] pphase_q, pphase_d;
`endif

  // Ready is decoded from state so it is low while reset is held.
  always_comb begin
    req_ready = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IDLE:  req_ready = 1'b1;
        S_RUN:   req_ready = !stop;
`ifdef CLKGEN_LDR_PEND_EN
        S_GAP,
        S_DUTY,
        S_PHASE,
        S_HOLD:  req_ready = !pend_q && !stop;
`endif
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign acc       = req_valid && req_ready;
  assign legal     = acc && (req_duty != '0);
  assign hold_last = (state_q == S_HOLD) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
`ifdef CLKGEN_LDR_PEND_EN
    pend_d   = pend_q;
    pduty_d  = pduty_q;
    pphase_d = pphase_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (legal) begin
          state_d = S_GAP;
          duty_d  = req_duty;
          phase_d = req_phase;
        end
      end
      S_GAP:   state_d = S_DUTY;
      S_DUTY:  state_d = S_PHASE;
      S_PHASE: begin
        state_d = S_HOLD;
        cnt_d   = CW'(MIN_RUN - 1);
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_RUN;
`ifdef CLKGEN_LDR_PEND_EN
          if (pend_q) begin
            state_d = S_GAP;
            duty_d  = pduty_q;
            phase_d = pphase_q;
            pend_d  = 1'b0;
          end else if (legal) begin
            state_d = S_GAP;
            duty_d  = req_duty;
            phase_d = req_phase;
          end
`endif
        end
      end
      S_RUN: begin
        if (legal) begin
          state_d = S_GAP;
          duty_d  = req_duty;
          phase_d = req_phase;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CLKGEN_LDR_PEND_EN
    // Early requests park here until the hold window ends.
    if (legal && !hold_last &&
        (state_q inside {S_GAP, S_DUTY, S_PHASE, S_HOLD})) begin
      pend_d   = 1'b1;
      pduty_d  = req_duty;
      pphase_d = req_phase;
    end
`endif
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
`ifdef CLKGEN_LDR_PEND_EN
      pend_d  = 1'b0;
`endif
    end
  end

  always_comb begin
    go_d   = state_d inside {S_DUTY, S_PHASE, S_HOLD, S_RUN};
    busy_d = (state_d != S_IDLE);
    ld_d   = (state_q == S_PHASE) && (state_d == S_HOLD);
    err_d  = acc && (req_duty == '0);
    unique case (state_d)
      S_DUTY:  din_d = duty_d;
      S_PHASE,
      S_HOLD,
      S_RUN:   din_d = phase_d;
      default: din_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

`ifdef CLKGEN_LDR_PEND_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= 1'b0;
      pduty_q  <= '0;
      pphase_q <= '0;
    end else begin
      pend_q   <= pend_d;
      pduty_q  <= pduty_d;
      pphase_q <= pphase_d;
    end
  end
`endif

  assign go     = go_q;
  assign datain = din_q;
  assign busy   = busy_q;
  assign loaded = ld_q;
  assign err    = err_q;

endmodule

// File: tb/tb_clkgen_cfg_loader.sv
// tb_clkgen_cfg_loader: directed plan plus random traffic checked each
// cycle against a timeline model of the load protocol.
module tb_clkgen_cfg_loader;

  localparam int DW      = 3;
  localparam int MIN_RUN = 8;
  localparam int HL      = 3 + MIN_RUN;
`ifdef CLKGEN_LDR_PEND_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [DW-1:0] req_duty = '0;
  logic [DW-1:0] req_phase = '0;
  logic          stop = 1'b0;
  logic          req_ready;
  logic          go;
  logic [DW-1:0] datain;
  logic          busy;
  logic          loaded;
  logic          err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clkgen_cfg_loader #(.DW(DW), .MIN_RUN(MIN_RUN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_duty  (req_duty),
    .req_phase (req_phase),
    .req_ready (req_ready),
    .stop      (stop),
    .go        (go),
    .datain    (datain),
    .busy      (busy),
    .loaded    (loaded),
    .err       (err)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since a launch edge (1=gap, 2=duty, 3=phase,
  // 4..HL=hold window, >HL=running).
  bit            m_act, m_pend, m_err;
  int            m_t;
  logic [DW-1:0] m_d, m_p, m_pd, m_pp;

  function automatic bit m_ready();
    if (!rst) return 1'b0;
    if (!m_act) return 1'b1;
    if (m_t > HL) return !stop;
    return PEND && !m_pend && !stop;
  endfunction

  function automatic logic [DW-1:0] m_din();
    if (!m_act || m_t == 1) return '0;
    if (m_t == 2) return m_d;
    return m_p;
  endfunction

  task automatic launch(input logic [DW-1:0] d, input logic [DW-1:0] p);
    m_act = 1'b1;
    m_t   = 1;
    m_d   = d;
    m_p   = p;
  endtask

  always @(posedge clk or negedge rst) begin
    bit acc, legal;
    if (!rst) begin
      m_act  = 1'b0;
      m_pend = 1'b0;
      m_err  = 1'b0;
      m_t    = 0;
    end else begin
      acc   = req_valid && m_ready();
      legal = acc && (req_duty != 0);
      m_err = acc && (req_duty == 0);
      if (m_act && stop) begin
        m_act  = 1'b0;
        m_pend = 1'b0;
      end else if (!m_act) begin
        if (legal) launch(req_duty, req_phase);
      end else if (m_t == HL && m_pend) begin
        launch(m_pd, m_pp);
        m_pend = 1'b0;
      end else if (legal && m_t >= HL) begin
        launch(req_duty, req_phase);
      end else begin
        if (legal) begin
          m_pend = 1'b1;
          m_pd   = req_duty;
          m_pp   = req_phase;
        end
        if (m_t < 100000) m_t++;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("ready",  req_ready, m_ready());
    chk("go",     go,        m_act && m_t >= 2);
    chk("datain", datain,    m_din());
    chk("busy",   busy,      m_act);
    chk("loaded", loaded,    m_act && m_t == 4);
    chk("err",    err,       m_err);
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d,
                     input logic [DW-1:0] p, input logic s);
    @(negedge clk);
    req_valid = v;
    req_duty  = d;
    req_phase = p;
    stop      = s;
    #2;
  endtask

  task automatic gd(input string nm, input logic g, input logic [DW-1:0] d);
    chk({nm, "_go"}, go, g);
    chk({nm, "_din"}, datain, d);
  endtask

  initial begin
    repeat (2) cyc(0, 0, 0, 0);
    chk("rst_go", go, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0);

    // accept {1,3} from idle
    cyc(1, 1, 3, 0);
    chk("t1_ready", req_ready, 1);
    cyc(0, 0, 0, 0); gd("t1_gap", 0, 0);
    chk("t1_busy", busy, 1);
    cyc(0, 0, 0, 0); gd("t1_duty", 1, 1);
    cyc(0, 0, 0, 0); gd("t1_phase", 1, 3);
    cyc(0, 0, 0, 0); gd("t1_h1", 1, 3);
    chk("t1_loaded", loaded, 1);
    chk("t1_h1_rdy", req_ready, PEND);
    for (int i = 2; i <= MIN_RUN; i++) begin
      cyc(0, 0, 0, 0);
      chk("t1_hold_rdy", req_ready, PEND);
      chk("t1_hold_ld", loaded, 0);
    end
    cyc(0, 0, 0, 0); gd("t1_run", 1, 3);
    chk("t1_run_rdy", req_ready, 1);

    // reload {5,1} from run
    cyc(1, 5, 1, 0);
    chk("t2_ready", req_ready, 1);
    cyc(0, 0, 0, 0); gd("t2_gap", 0, 0);
    cyc(0, 0, 0, 0); gd("t2_duty", 1, 5);
    cyc(0, 0, 0, 0); gd("t2_phase", 1, 1);
    cyc(0, 0, 0, 0); chk("t2_loaded", loaded, 1);
    for (int i = 2; i <= MIN_RUN; i++) begin
      cyc(0, 0, 0, 0);
      chk("t2_hold_rdy", req_ready, PEND);
    end
    cyc(0, 0, 0, 0);
    chk("t2_run_rdy", req_ready, 1);

    // stop beats a simultaneous request in run
    cyc(1, 6, 2, 1);
    chk("t3_ready", req_ready, 0);
    cyc(0, 0, 0, 0); gd("t3_stop", 0, 0);
    chk("t3_busy", busy, 0);
    cyc(0, 0, 0, 0); gd("t3_idle", 0, 0);
    chk("t3_busy2", busy, 0);

    // illegal duty in idle
    cyc(1, 0, 5, 0);
    chk("t4_ready", req_ready, 1);
    cyc(0, 0, 0, 0);
    chk("t4_err", err, 1);
    chk("t4_go", go, 0);
    chk("t4_busy", busy, 0);
    cyc(0, 0, 0, 0);
    chk("t4_err_off", err, 0);

    // stop during duty cycle
    cyc(1, 3, 2, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); gd("t5_duty", 1, 3);
    cyc(0, 0, 0, 0); gd("t5_stop", 0, 0);
    chk("t5_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0);
      chk("t5_noload", loaded, 0);
    end

    // second request in the 2nd hold cycle
    cyc(1, 1, 3, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_h1", loaded, 1);
    cyc(1, 2, 4, 0);
    chk("t6_ready", req_ready, PEND);
`ifdef CLKGEN_LDR_PEND_EN
    for (int i = 3; i <= MIN_RUN; i++) cyc(0, 0, 0, 0);
    gd("t6_h8", 1, 3);
`else
    for (int i = 3; i <= MIN_RUN; i++) begin
      cyc(1, 2, 4, 0);
      chk("t6_hold_rdy", req_ready, 0);
    end
    cyc(1, 2, 4, 0); gd("t6_run", 1, 3);
    chk("t6_run_rdy", req_ready, 1);
`endif
    cyc(0, 0, 0, 0); gd("t6_gap", 0, 0);
    cyc(0, 0, 0, 0); gd("t6_duty", 1, 2);
    cyc(0, 0, 0, 0); gd("t6_phase", 1, 4);

    // reset mid-sequence drops go at once
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("t7_go", go, 0);
    chk("t7_busy", busy, 0);
    cyc(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk("t7_ready", req_ready, 1);
    cyc(0, 0, 0, 0);
    chk("t7_idle", go, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 499) != 0);
      req_valid = $urandom_range(0, 1);
      req_duty  = DW'($urandom_range(0, 7));
      req_phase = DW'($urandom_range(0, 7));
      stop      = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    stop      = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkgen_cfg_loader.md
Name: clkgen_cfg_loader

Overview:
- Upstream command stage for the clock generator. Accepts a parallel {duty, phase} request over a valid/ready handshake.
- Serialises each request into the generator's go/datain load protocol:
  - one cycle with go=0 and datain=0;
  - go=1 with datain=duty;
  - go=1 with datain=phase;
  - go held high while the generator runs.
- Enforces a minimum run window before the next reload, supports an explicit stop, and rejects illegal duty values.

Parameters:
- DW, 3: width of duty, phase and datain.
- MIN_RUN, 8: cycles go must stay high after the phase cycle before a new request can be launched. Legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_duty  in  DW  requested duty cycle; 0 is illegal.
- req_phase  in  DW  requested phase; all values legal.
- req_ready  out  1  request can be accepted this cycle.
- stop  in  1  stop the running generator.
- go  out  1  to generator go.
- datain  out  DW  to generator datain.
- busy  out  1  high whenever the state is not IDLE.
- loaded  out  1  one-cycle pulse on entry to HOLD.
- err  out  1  one-cycle pulse when a request with duty=0 is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - Outputs: go=0, datain=0, req_ready=0 during reset, busy=0, loaded=0, err=0.
  - Internal duty/phase registers and the hold counter are cleared.
- All outputs are registered; values below are those present during the named state.
- A request is accepted on a rising edge with req_valid & req_ready. Duty and phase are captured at that edge.
- A request with duty=0 is still accepted (ready handshake completes), but:
  - err pulses the next cycle;
  - the state is unchanged and go/datain are untouched.
- States:
  - IDLE: go=0, datain=0, req_ready=1. A valid legal accept moves to GAP.
  - GAP (1 cycle): go=0, datain=0, req_ready=0. Moves to DUTY.
  - DUTY (1 cycle): go=1, datain=duty, req_ready=0. Moves to PHASE.
  - PHASE (1 cycle): go=1, datain=phase, req_ready=0. Moves to HOLD; hold counter loads MIN_RUN-1.
  - HOLD:
    - go=1, datain=phase, req_ready=0, loaded=1 in the first HOLD cycle only.
    - The counter decrements each cycle; moves to RUN in the cycle after it reaches 0.
    - This gives exactly MIN_RUN HOLD cycles.
  - RUN: go=1, datain=phase, req_ready=1. A legal accept moves to GAP, so go drops for exactly one cycle and the reload sequence follows.
- Latency: accept at edge N gives GAP at N+1, DUTY at N+2, PHASE at N+3, loaded at N+4.
- stop:
  - Sampled in GAP, DUTY, PHASE, HOLD and RUN; moves to IDLE at the next edge.
  - go=0 from that edge. Any in-flight sequence is abandoned.
  - Ignored in IDLE.
- Simultaneous stop and accept in RUN: stop wins. The request is not accepted because req_ready is combinationally forced low when stop=1.
- Reset asserted mid-sequence: go drops immediately (asynchronously); no partial load resumes after reset is released.
- The hold counter is $clog2(MIN_RUN+1) bits wide and never wraps; it saturates at 0.

Optional Feature:
CLKGEN_LDR_PEND_EN
- Defined: adds a one-entry pending register.
  - In GAP, DUTY, PHASE and HOLD, req_ready = !pend_full & !stop, so one request can be accepted early.
  - Duty=0 requests still only pulse err and are not stored.
  - A pending entry launches (moves to GAP) in the cycle the state would otherwise enter RUN.
  - In that case RUN is skipped and go drops one cycle after the last HOLD cycle.
  - stop clears the pending entry.
- Undefined: no pending register; req_ready is high only in IDLE and RUN, exactly as described above.

Test Plan:
- Reset then accept {duty=1, phase=3} in IDLE.
  - Next 3 cycles (go, datain) = (0,0), (1,1), (1,3).
  - loaded pulses one cycle later; go=1 and datain=3 held; req_ready=0 for 8 cycles, then 1.
- In RUN, accept {duty=5, phase=1}.
  - go=0 and datain=0 for exactly 1 cycle, then (1,5), (1,1).
  - HOLD lasts MIN_RUN=8 cycles before req_ready rises.
- Request with duty=0 in IDLE: ready completes, err=1 for one cycle, go stays 0, busy stays 0.
- Assert stop in the DUTY cycle: go=0 at the next edge, state IDLE, busy=0, no loaded pulse.
- stop and req_valid both high in RUN: req_ready=0, request not consumed, go=0 at the next edge.
- With CLKGEN_LDR_PEND_EN, second request {duty=2, phase=4} in the 2nd HOLD cycle:
  - accepted immediately;
  - after the 8th HOLD cycle the bench sees (0,0), (1,2), (1,4) with no RUN cycle in between.
- With CLKGEN_LDR_PEND_EN undefined, the same stimulus is not accepted until RUN.
